i2s_slave_rx: RTL and testbench

// - Far end of the I2S link driven by the APB I2S controller: an I2S slave receiver. It takes external sck/ws/sd,

---
 rtl/i2s_pkg.sv | 6 +
 rtl/i2s_slave_rx_if.sv | 8 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/i2s_slave_rx.sv | 105 ++++++++++
 tb/tb_i2s_slave_rx.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared FSM states and channel constants for the I2S slave receiver
package i2s_pkg;
    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_slave_rx_if.sv
// i2s_slave_rx_if: valid/ready stream carrying {left,right} frames out of the receiver
interface i2s_slave_rx_if #(parameter int DW = 16);
    logic              frame_valid;
    logic [2*DW-1:0]   frame_data;
    logic              frame_ready;
    modport master (output frame_valid, frame_data, input frame_ready);
    modport slave  (input frame_valid, frame_data, output frame_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock frame FIFO; a push into a full FIFO only lands when a pop frees the slot
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [WIDTH-1:0]             dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    // pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    // storage needs no reset: dout is masked while empty
    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: I2S slave receiver; oversamples sck/ws/sd, deserialises Philips stereo words, queues {L,R} frames
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int DW          = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         sck_i,
    input  logic                         ws_i,
    input  logic                         sd_i,
    i2s_slave_rx_if.master               frm,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
    output logic                         overflow_o,
    output logic                         len_err_o,
    input  logic                         clr_i
);
    localparam int CW = $clog2(DW+1);
    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_s, ws_s, sd_s, sck_d, sck_rise, ws_prev;
    state_t                 state, state_nx;
    logic [CW-1:0]          bitcnt;
    logic [DW-1:0]          shreg, sh_nx, left_hold;
    logic                   cap, word_end, push, full, empty, ovf_set, lerr_set;
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_d;
    // synchronisers, sck edge detector and the ws history used for word boundaries
    always_ff @(posedge pclk) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
            ws_prev  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_i};
            sck_d    <= sck_s;
            if (sck_rise) ws_prev <= ws_s;
        end
    end
    // FSM state register
    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state plus the per-edge word assembly decisions
    always_comb begin
        state_nx = !en_i ? IDLE :
                   state == IDLE ? ALIGN :
                   (state == ALIGN && sck_rise && ws_prev == CH_RIGHT && ws_s == CH_LEFT) ? RUN : state;
        cap      = state == RUN && en_i && sck_rise;
        word_end = cap && ws_s != ws_prev;
        sh_nx    = bitcnt < CW'(DW) ? shreg | (DW'(sd_s) << (CW'(DW-1) - bitcnt)) : shreg;
        push     = word_end && ws_prev == CH_RIGHT;
        lerr_set = word_end && (32'(bitcnt) + 1 < DW);
        ovf_set  = push && full && !frm.frame_ready;
    end
    // deserialiser: shift register, saturating bit counter and held left sample
    always_ff @(posedge pclk) begin
        if (rst) begin
            bitcnt    <= '0;
            shreg     <= '0;
            left_hold <= '0;
        end else if (state != RUN || !en_i) begin
            bitcnt <= '0;
            shreg  <= '0;
        end else if (word_end) begin
            bitcnt <= '0;
            shreg  <= '0;
            if (ws_prev == CH_LEFT) left_hold <= sh_nx;
        end else if (cap) begin
            bitcnt <= bitcnt == CW'(DW) ? bitcnt : bitcnt + 1'b1;
            shreg  <= sh_nx;
        end
    end
    // sticky error flags; a new set beats a simultaneous clear
    always_ff @(posedge pclk) begin
        if (rst) begin
            overflow_o <= 1'b0;
            len_err_o  <= 1'b0;
        end else begin
            overflow_o <= ovf_set || (overflow_o && !clr_i);
            len_err_o  <= lerr_set || (len_err_o && !clr_i);
        end
    end
    assign frm.frame_valid = !empty;
    sync_fifo #(.WIDTH(2*DW), .DEPTH(DEPTH)) u_fifo (
        .pclk  (pclk),
        .rst   (rst),
        .push  (push),
        .din   ({left_hold, sh_nx}),
        .pop   (frm.frame_ready),
        .full  (full),
        .empty (empty),
        .level (fifo_level_o),
        .dout  (frm.frame_data)
    );
endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: I2S master BFM at sck = pclk/8 with a frame scoreboard for i2s_slave_rx
module tb_i2s_slave_rx;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    logic pclk = 1'b0, rst = 1'b1, en_i = 1'b0, sck_i = 1'b0, ws_i = 1'b0, sd_i = 1'b0, clr_i = 1'b0;
    logic [3:0] fifo_level_o;
    logic overflow_o, len_err_o;
    int total = 0, bad = 0;
    logic [31:0] exp_q[$];
    bit exp_lerr = 1'b0;
    i2s_slave_rx_if #(.DW(DW)) frm();
    i2s_slave_rx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .rst(rst), .en_i(en_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
        .frm(frm), .fifo_level_o(fifo_level_o), .overflow_o(overflow_o),
        .len_err_o(len_err_o), .clr_i(clr_i)
    );
    always #5 pclk = ~pclk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask
    task automatic send_bit(input logic w, input logic d);
        sck_i = 1'b0;
        ws_i = w;
        sd_i = d;
        #40;
        sck_i = 1'b1;
        #40;
    endtask
    // sample value the receiver should hold for an n-bit word: MSBs kept, short words left-justified
    function automatic logic [15:0] fit(input logic [31:0] w, input int n);
        logic [31:0] t;
        t = w & ((32'd1 << n) - 1);
        t = n >= 16 ? t >> (n - 16) : t << (16 - n);
        return t[15:0];
    endfunction
    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(i == 0, l[i]);
        for (int i = n - 1; i >= 1; i--) send_bit(1'b1, r[i]);
        if (n < DW) exp_lerr = 1'b1;
        if (frm.frame_ready || exp_q.size() < DEPTH) exp_q.push_back({fit(l, n), fit(r, n)});
        send_bit(1'b0, r[0]);
    endtask
    // re-enable and send a throwaway right word whose LSB gives the 1->0 ws edge used to align
    task automatic start_stream();
        en_i = 1'b0;
        step(3);
        en_i = 1'b1;
        step(3);
        for (int i = 15; i >= 1; i--) send_bit(1'b1, 1'($urandom));
        send_bit(1'b0, 1'($urandom));
    endtask
    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || frm.frame_valid); i++) step(1);
        chk("drain_pending", 64'(exp_q.size()), 0);
        chk("drain_valid", frm.frame_valid, 0);
    endtask
    task automatic pulse_clr();
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        exp_lerr = 1'b0;
        step(1);
    endtask
    // monitor: every accepted frame must match the oldest expected frame
    always @(negedge pclk) begin
        if (!rst && frm.frame_valid && frm.frame_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_frame: got %0h, expected none", frm.frame_data);
            end else begin
                chk("frame", frm.frame_data, exp_q.pop_front());
            end
        end
    end
    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] l, r;
        frm.frame_ready = 1'b0;
        step(3);
        chk("rst_valid", frm.frame_valid, 0);
        chk("rst_data", frm.frame_data, 0);
        chk("rst_level", fifo_level_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_lerr", len_err_o, 0);
        rst = 1'b0;
        step(2);
        frm.frame_ready = 1'b1;
        start_stream();
        send_frame(32'hA5C3, 32'h0F0F, 16);
        send_frame(32'h8001, 32'h7FFE, 16);
        drain();
        chk("t1_lerr", len_err_o, 0);
        for (int k = 0; k < 6; k++) send_frame($urandom, $urandom, int'($urandom_range(10, 24)));
        drain();
        chk("rand_lerr", len_err_o, exp_lerr);
        pulse_clr();
        chk("rand_lerr_clr", len_err_o, 0);
        frm.frame_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) send_frame($urandom, $urandom, 16);
        step(5);
        chk("t2_level", fifo_level_o, DEPTH);
        chk("t2_ovf", overflow_o, 1);
        frm.frame_ready = 1'b1;
        drain();
        pulse_clr();
        chk("t2_ovf_clr", overflow_o, 0);
        send_frame(32'h123456, 32'hABCDEF, 24);
        drain();
        chk("t3_lerr24", len_err_o, 0);
        send_frame(32'hABC, 32'h5A5, 12);
        drain();
        chk("t3_lerr12", len_err_o, exp_lerr);
        pulse_clr();
        for (int i = 15; i >= 8; i--) send_bit(1'b0, 1'b1);
        en_i = 1'b0;
        step(4);
        start_stream();
        send_frame(32'h1111, 32'h2222, 16);
        drain();
        chk("t4_lerr", len_err_o, 0);
        frm.frame_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send_frame($urandom, $urandom, 16);
        step(5);
        chk("t5_full", fifo_level_o, DEPTH);
        l = $urandom & 32'hFFFF;
        r = $urandom & 32'hFFFF;
        for (int i = 15; i >= 0; i--) send_bit(i == 0, l[i]);
        for (int i = 15; i >= 1; i--) send_bit(1'b1, r[i]);
        exp_q.push_back({l[15:0], r[15:0]});
        sck_i = 1'b0;
        ws_i = 1'b0;
        sd_i = r[0];
        #40;
        sck_i = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        frm.frame_ready = 1'b1;
        @(posedge pclk);
        #1;
        frm.frame_ready = 1'b0;
        #10;
        step(3);
        chk("t5_level", fifo_level_o, DEPTH);
        chk("t5_ovf", overflow_o, 0);
        chk("t5_pending", 64'(exp_q.size()), DEPTH);
        frm.frame_ready = 1'b1;
        drain();
        frm.frame_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_frame($urandom, $urandom, 12);
        step(5);
        chk("t6_level3", fifo_level_o, 3);
        chk("t6_lerr_set", len_err_o, 1);
        for (int i = 15; i >= 11; i--) send_bit(1'b0, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        exp_lerr = 1'b0;
        step(1);
        chk("t6_valid", frm.frame_valid, 0);
        chk("t6_level", fifo_level_o, 0);
        chk("t6_ovf", overflow_o, 0);
        chk("t6_lerr", len_err_o, 0);
        rst = 1'b0;
        frm.frame_ready = 1'b1;
        start_stream();
        send_frame(32'hCAFE, 32'hBEEF, 16);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
